// File: rtl/psg_bus_writer.sv
// psg_bus_writer: serialises PSG register writes into latch/data bytes with an active-low strobe.
// Define PSG_SHADOW_SKIP_EN to drop tone data bytes that match the last value written.
module psg_bus_writer #(
    parameter int WE_CYCLES  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_reg,
    input  logic [9:0] req_value,
    output logic [7:0] bus_data,
    output logic       bus_we_n,
    output logic       busy
);
    localparam int MAXC = WE_CYCLES > GAP_CYCLES ? WE_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] WE_LOAD = CW'(WE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0] IDLE = 3'd0, LATCH_ASSERT = 3'd1, LATCH_GAP = 3'd2,
                           DATA_ASSERT = 3'd3, DATA_GAP = 3'd4;

    logic [2:0] state, nxt, data_or_idle;
    logic [CW-1:0] cnt;
    logic [5:0] hi;
    logic send_data, tone, req_data, done;
    logic [7:0] latch_byte;

    assign req_ready = rst_n && state == IDLE;
    assign busy = state != IDLE;
    assign bus_we_n = !(state == LATCH_ASSERT || state == DATA_ASSERT);
    assign done = cnt == '0;
    assign tone = !req_reg[0] && req_reg[2:1] != 2'b11;
    assign latch_byte = {1'b1, req_reg, req_reg == 3'b110 ? {1'b0, req_value[2:0]} : req_value[3:0]};
    assign data_or_idle = send_data ? DATA_ASSERT : IDLE;

`ifdef PSG_SHADOW_SKIP_EN
    logic [5:0] shadow [4];
    logic [3:0] shadow_valid;
    logic [1:0] cur_idx;
    assign req_data = tone && !(shadow_valid[req_reg[2:1]] && shadow[req_reg[2:1]] == req_value[9:4]);
    // shadow only records tone writes whose data byte actually went out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_valid <= '0;
            cur_idx <= '0;
        end else begin
            if (state == IDLE && req_valid)
                cur_idx <= req_reg[2:1];
            if (state == DATA_ASSERT && done) begin
                shadow[cur_idx] <= hi;
                shadow_valid[cur_idx] <= 1'b1;
            end
        end
    end
`else
    assign req_data = tone;
`endif

    // zero-length gap states are skipped outright
    always_comb begin
        nxt = state;
        if (state == IDLE && req_valid)
            nxt = LATCH_ASSERT;
        else if (state != IDLE && done)
            nxt = state == LATCH_ASSERT ? (GAP_CYCLES > 0 ? LATCH_GAP : data_or_idle) :
                  state == LATCH_GAP    ? data_or_idle :
                  state == DATA_ASSERT  ? (GAP_CYCLES > 0 ? DATA_GAP : IDLE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bus_data <= 8'h00;
            send_data <= 1'b0;
            hi <= '0;
        end else begin
            state <= nxt;
            if (nxt != state)
                cnt <= (nxt == LATCH_ASSERT || nxt == DATA_ASSERT) ? WE_LOAD : GAP_LOAD;
            else if (!done)
                cnt <= cnt - 1'b1;
            if (state == IDLE && req_valid) begin
                bus_data <= latch_byte;
                hi <= req_value[9:4];
                send_data <= req_data;
            end else if (nxt == DATA_ASSERT && state != DATA_ASSERT)
                bus_data <= {2'b00, hi};
        end
    end
endmodule
